// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Conditions the board slide switches. Each raw pin is brought into the clk
// domain through a two-flop synchroniser and then debounced by its own
// stability counter. The clean levels are published as a bus and, in
// addition, every accepted level change is reported once through a
// valid/ready event stream.
//
// Parameters
//   WIDTH      number of switch inputs
//   DB_CYCLES  consecutive stable cycles needed to accept a new level
//              (legal range 1 .. 2**CNT_W-1)
//   CNT_W      width of each per-bit stability counter
//
// Ports
//   clk        system clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   sw         raw switch pins (asynchronous, may bounce)
//   sw_clean   debounced switch levels
//   evt_valid  a change event is pending
//   evt_ready  consumer accepts the pending event this cycle
//   evt_data   sw_clean value after the most recent change
//   evt_mask   bits changed since the last accepted event (1 = changed)
//   overrun    one-cycle pulse: a change was merged into an unaccepted event
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_mask,
  output logic             overrun
);

  // Terminal count: reaching it while the input still disagrees flips the
  // clean level, so a new level needs DB_CYCLES consecutive disagreeing cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Synchroniser
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Debounce state
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            clean_q;
  logic [WIDTH-1:0]            clean_d;
  logic [WIDTH-1:0]            chg;

  // Event state
  logic             evt_valid_q;
  logic             evt_valid_d;
  logic [WIDTH-1:0] evt_data_q;
  logic [WIDTH-1:0] evt_data_d;
  logic [WIDTH-1:0] evt_mask_q;
  logic [WIDTH-1:0] evt_mask_d;
  logic             overrun_q;
  logic             overrun_d;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; nothing else looks at the raw pins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit stability counters. The counter only runs while the synchronised
  // input disagrees with the clean level; any cycle of agreement clears it.
  // At the terminal count the clean bit flips and the counter clears, so it
  // can never exceed CNT_LAST and never wraps.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic diff;
      logic at_last;

      assign diff       = s2_q[gi] ^ clean_q[gi];
      assign at_last    = (cnt_q[gi] == CNT_LAST);
      assign chg[gi]    = diff & at_last;
      assign cnt_d[gi]  = (diff && !at_last) ? cnt_q[gi] + 1'b1 : '0;
    end
  endgenerate

  assign clean_d = clean_q ^ chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event register. Decisions use only registered evt_valid plus evt_ready, so
  // evt_ready never reaches evt_valid combinationally.
  // A change arriving on the same edge as a handshake starts a fresh event
  // (the accepted mask is not carried over). A change arriving while the
  // event is pending and not accepted is merged and flagged as an overrun.
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_mask_d  = evt_mask_q;
    overrun_d   = 1'b0;

    if (chg != '0) begin
      evt_valid_d = 1'b1;
      evt_data_d  = clean_d;
      if (!evt_valid_q || evt_ready) begin
        evt_mask_d = chg;
      end else begin
        evt_mask_d = evt_mask_q | chg;
        overrun_d  = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      // Accepted with nothing new: data and mask hold until the next load.
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_mask_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_mask_q  <= evt_mask_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sw_clean  = clean_q;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign evt_mask  = evt_mask_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DB_CYCLES=4. Inputs are changed 1 time
// unit after a rising edge and outputs are sampled at that same point, so
// "edge k" below means the k-th rising edge after the input change (edge 1 is
// the first edge that samples the new pin value). A new level is expected on
// sw_clean after edge DB_CYCLES+2 = 6.
module tb_sw_debounce;

  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_clean;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic [WIDTH-1:0] evt_mask;
  logic             overrun;

  int tests_run;
  int tests_failed;

  sw_debounce #(
    .WIDTH    (WIDTH),
    .DB_CYCLES(DB),
    .CNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_clean (sw_clean),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data (evt_data),
    .evt_mask (evt_mask),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted for two edges, released 1 unit after an edge.
  task automatic apply_reset(input logic [WIDTH-1:0] sw_val, input logic rdy);
    rst_n     = 1'b0;
    sw        = sw_val;
    evt_ready = rdy;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(8'h00, 1'b0);
    tests_run++;
    if ({sw_clean, evt_valid, evt_data, evt_mask, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: clean=%h valid=%b data=%h mask=%h ovr=%b required all 0",
               sw_clean, evt_valid, evt_data, evt_mask, overrun);
    end
    $display("[TB] test_reset: clean=%h valid=%b", sw_clean, evt_valid);
  endtask

  task automatic test_single_event();
    apply_reset(8'h00, 1'b1);
    sw = 8'h01;
    for (int k = 1; k <= DB + 2; k++) begin
      tick();
      tests_run++;
      if (overrun !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_overrun edge %0d: got %b required 0", k, overrun);
      end
      if (k < DB + 2) begin
        tests_run++;
        if (sw_clean !== 8'h00 || evt_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_early edge %0d: clean=%h valid=%b required 00/0", k, sw_clean, evt_valid);
        end
      end
    end
    tests_run++;
    if (sw_clean !== 8'h01 || evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_mask !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_event: clean=%h valid=%b data=%h mask=%h required 01/1/01/01",
               sw_clean, evt_valid, evt_data, evt_mask);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || overrun !== 1'b0 || evt_mask !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_accept: valid=%b ovr=%b mask=%h required 0/0/01", evt_valid, overrun, evt_mask);
    end
    $display("[TB] test_single_event: clean=%h data=%h mask=%h", sw_clean, evt_data, evt_mask);
  endtask

  task automatic test_bounce();
    logic seen_valid;
    seen_valid = 1'b0;
    apply_reset(8'h00, 1'b1);
    for (int k = 0; k < 20; k++) begin
      sw = ((k / 2) % 2 == 0) ? 8'h02 : 8'h00;
      tick();
      if (evt_valid === 1'b1 || sw_clean !== 8'h00) seen_valid = 1'b1;
    end
    sw = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (evt_valid === 1'b1 || sw_clean !== 8'h00) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_reject: clean/valid activity seen=%b required 0", seen_valid);
    end
    tests_run++;
    if (sw_clean !== 8'h00) begin
      tests_failed++;
      $display("FAIL bounce_clean: got %h required 00", sw_clean);
    end
    $display("[TB] test_bounce: clean=%h", sw_clean);
  endtask

  task automatic test_merge();
    apply_reset(8'h00, 1'b0);
    sw = 8'h01;
    for (int k = 1; k <= DB + 2; k++) tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_mask !== 8'h01 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL merge_first: valid=%b data=%h mask=%h ovr=%b required 1/01/01/0",
               evt_valid, evt_data, evt_mask, overrun);
    end
    for (int k = DB + 3; k <= 10; k++) tick();
    sw = 8'h03;
    for (int k = 1; k < DB + 2; k++) begin
      tick();
      tests_run++;
      if (evt_valid !== 1'b1 || evt_data !== 8'h01 || evt_mask !== 8'h01 || overrun !== 1'b0) begin
        tests_failed++;
        $display("FAIL merge_hold edge %0d: valid=%b data=%h mask=%h ovr=%b required 1/01/01/0",
                 k, evt_valid, evt_data, evt_mask, overrun);
      end
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== 8'h03 || evt_mask !== 8'h03 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL merge_second: valid=%b data=%h mask=%h ovr=%b required 1/03/03/1",
               evt_valid, evt_data, evt_mask, overrun);
    end
    tick();
    tests_run++;
    if (overrun !== 1'b0 || evt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL merge_pulse: ovr=%b valid=%b required 0/1", overrun, evt_valid);
    end
    evt_ready = 1'b1;
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || evt_data !== 8'h03 || evt_mask !== 8'h03) begin
      tests_failed++;
      $display("FAIL merge_accept: valid=%b data=%h mask=%h required 0/03/03", evt_valid, evt_data, evt_mask);
    end
    $display("[TB] test_merge: data=%h mask=%h", evt_data, evt_mask);
  endtask

  task automatic test_back_to_back();
    apply_reset(8'h00, 1'b0);
    sw = 8'h01;
    for (int k = 1; k <= DB + 2; k++) tick();
    sw = 8'h05;
    for (int k = 1; k < DB + 2; k++) tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_mask !== 8'h01 || evt_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL b2b_pending: valid=%b data=%h mask=%h required 1/01/01", evt_valid, evt_data, evt_mask);
    end
    evt_ready = 1'b1;
    tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_mask !== 8'h04 || evt_data !== 8'h05 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_reload: valid=%b data=%h mask=%h ovr=%b required 1/05/04/0",
               evt_valid, evt_data, evt_mask, overrun);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b0 || sw_clean !== 8'h05) begin
      tests_failed++;
      $display("FAIL b2b_drain: valid=%b clean=%h required 0/05", evt_valid, sw_clean);
    end
    $display("[TB] test_back_to_back: data=%h mask=%h", evt_data, evt_mask);
  endtask

  // Starts from the state left by test_back_to_back (sw_clean=0x05).
  task automatic test_reset_mid();
    evt_ready = 1'b1;
    sw = 8'h80;
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({sw_clean, evt_valid, evt_data, evt_mask, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: clean=%h valid=%b data=%h mask=%h ovr=%b required all 0",
               sw_clean, evt_valid, evt_data, evt_mask, overrun);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k < DB + 2; k++) begin
      tick();
      tests_run++;
      if (sw_clean !== 8'h00 || evt_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_early edge %0d: clean=%h valid=%b required 00/0", k, sw_clean, evt_valid);
      end
    end
    tick();
    tests_run++;
    if (sw_clean !== 8'h80 || evt_valid !== 1'b1 || evt_mask !== 8'h80 || evt_data !== 8'h80) begin
      tests_failed++;
      $display("FAIL reset_mid_event: clean=%h valid=%b data=%h mask=%h required 80/1/80/80",
               sw_clean, evt_valid, evt_data, evt_mask);
    end
    $display("[TB] test_reset_mid: clean=%h mask=%h", sw_clean, evt_mask);
  endtask

  task automatic test_all_ones();
    apply_reset(8'hFF, 1'b1);
    for (int k = 1; k < DB + 2; k++) tick();
    tests_run++;
    if (evt_valid !== 1'b0 || sw_clean !== 8'h00) begin
      tests_failed++;
      $display("FAIL all_ones_early: valid=%b clean=%h required 0/00", evt_valid, sw_clean);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_data !== 8'hFF || evt_mask !== 8'hFF || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_ones_event: valid=%b data=%h mask=%h ovr=%b required 1/FF/FF/0",
               evt_valid, evt_data, evt_mask, overrun);
    end
    tick();
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_ones_single: valid=%b required 0", evt_valid);
    end
    $display("[TB] test_all_ones: data=%h mask=%h", evt_data, evt_mask);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    sw           = '0;
    evt_ready    = 1'b0;
    #3;
    test_reset();
    test_single_event();
    test_bounce();
    test_merge();
    test_back_to_back();
    test_reset_mid();
    test_all_ones();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the eight board slide switches for the logic that drives the LED/segment patterns. It synchronises each raw switch into the `clk` domain and debounces it with a per-bit stability counter. It publishes a clean level bus plus a valid/ready change-event stream, so downstream pattern logic reacts once per real switch movement instead of sampling raw pins.

## Interface
- `WIDTH`, 8: number of switch inputs.
- `DB_CYCLES`, 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz). Legal range 1..2^CNT_W-1.
- `CNT_W`, 16: width of each per-bit stability counter.

- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sw`  in  WIDTH  raw switch pins; asynchronous, may bounce.
- `sw_clean`  out  WIDTH  debounced switch levels.
- `evt_valid`  out  1  change event pending.
- `evt_ready`  in  1  consumer accepts event this cycle.
- `evt_data`  out  WIDTH  `sw_clean` value after the most recent change.
- `evt_mask`  out  WIDTH  bits that changed since last accepted event (1 = changed).
- `overrun`  out  1  one-cycle pulse: a change was merged into an unaccepted event.

## Operation
- Reset (`rst_n`=0, asynchronous): sync flops, counters, `sw_clean`, `evt_data`, `evt_mask` all 0; `evt_valid`=0; `overrun`=0. Holds regardless of `clk`.
- Synchroniser: two flops per bit, `sw` -> `s1` -> `s2`. No other logic touches raw `sw`.
- Per-bit debounce, bit i:
  - `s2[i]==sw_clean[i]`: counter cleared to 0.
  - `s2[i]!=sw_clean[i]` and counter < DB_CYCLES-1: counter +1.
  - `s2[i]!=sw_clean[i]` and counter == DB_CYCLES-1: `sw_clean[i]` toggles, counter cleared.
  - Any single-cycle return to equality restarts the count from 0.
  - Counter never wraps; it is bounded by DB_CYCLES-1.
- Change vector `chg` = bits toggling this cycle (combinational). Multiple bits may toggle on the same edge and form one event.
- Event register, evaluated each edge when `chg`≠0:
  - `evt_valid`=0, or (`evt_valid`=1 and `evt_ready`=1): load `evt_data`=new `sw_clean`, `evt_mask`=`chg`; `evt_valid`=1.
  - `evt_valid`=1 and `evt_ready`=0: merge. `evt_data`=new `sw_clean`, `evt_mask`|=`chg`, `evt_valid` stays 1, `overrun` pulses 1 for one cycle.
  - When `chg`=0, `evt_valid`=1 and `evt_ready`=1: `evt_valid`->0. `evt_data` and `evt_mask` hold their values, and `evt_mask` is not cleared until the next load.
- Merging is the only case where `evt_data`/`evt_mask` change while `evt_valid`=1. Consumers sample on the handshake cycle only.
- A bit that toggles and toggles back before acceptance stays set in `evt_mask`, and `evt_data` shows the current level.

## Timing
- Pin to `s2`: 2 cycles.
- `s2` change to `sw_clean` change: DB_CYCLES cycles if stable throughout.
- Total `sw` edge (first sampled) to `sw_clean`: DB_CYCLES+2 cycles.
- `evt_valid`, `evt_data` and `evt_mask` update on the same edge as `sw_clean`. There is no extra event latency.
- Handshake: transfer when `evt_valid`&`evt_ready` on a rising edge. `evt_ready` may be high while idle, with no effect. No combinational path from `evt_ready` to `evt_valid`.
- Throughput: one event per cycle when `evt_ready` is held high.
- Mid-operation reset: partial counts are discarded. After release, a switch already high re-debounces from 0 and produces an event after DB_CYCLES+2 cycles.

## Test plan
- DB_CYCLES=4, reset with `sw`=0x00, then `sw`=0x01 held, `evt_ready`=1 -> `sw_clean`=0x01 exactly 6 cycles after the first sampling edge; one-cycle `evt_valid` with `evt_data`=0x01, `evt_mask`=0x01; `overrun` never 1.
- DB_CYCLES=4, bit1 toggling every 2 cycles for 20 cycles then back to 0 -> `sw_clean` stays 0x00, `evt_valid` never asserts.
- DB_CYCLES=4, `evt_ready`=0; `sw` 0x00->0x01, then 10 cycles later ->0x03 -> first event `evt_data`=0x01/`evt_mask`=0x01; at the second change `evt_data`=0x03, `evt_mask`=0x03, `overrun` one-cycle pulse; raising `evt_ready` drops `evt_valid` next edge.
- Handshake and new change on the same edge (`evt_ready`=1, pending mask 0x01, bit2 toggles) -> `evt_valid` stays 1, `evt_mask`=0x04 (not merged), `overrun`=0.
- DB_CYCLES=4, `sw`=0x80 and reset asserted at count 2 -> all outputs 0 immediately; release with `sw` still 0x80 -> `sw_clean`=0x80, `evt_mask`=0x80 after 6 cycles.
- `sw`=0xFF at reset release -> single event with `evt_data`=0xFF and `evt_mask`=0xFF, all bits toggling on the same edge.
